// File: rtl/alu_seq_pkg.sv
// Shared opcode, ALU-encoding and state definitions for alu_op_sequencer.
// Also holds the opcode-to-ALU-control decoder used on command accept.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_XOR   = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_ADD32 = 4'd6;
  localparam logic [3:0] OP_SUB32 = 4'd7;
  localparam logic [3:0] OP_NOR   = 4'd8;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC_LO,
    S_EXEC_HI,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic       cin;
    logic       ainvert;
    logic       bnegate;
    logic       legal;
  } alu_ctl_t;

  // Control lines for the first (or only) ALU pass of an opcode.
  function automatic alu_ctl_t decode_op(input logic [3:0] opc);
    alu_ctl_t c;
    c = '0;
    c.legal = 1'b1;
    case (opc)
      OP_AND: c.op = ALU_AND;
      OP_OR:  c.op = ALU_OR;
      OP_XOR: c.op = ALU_XOR;
      OP_ADD, OP_ADD32: c.op = ALU_ADD;
      OP_SUB, OP_SLT, OP_SUB32: begin
        c.op      = ALU_ADD;
        c.bnegate = 1'b1;
        c.cin     = 1'b1;
      end
      // ~a & ~b is a NOR
      OP_NOR: begin
        c.op      = ALU_AND;
        c.ainvert = 1'b1;
        c.bnegate = 1'b1;
      end
      default: c.legal = 1'b0;
    endcase
    return c;
  endfunction

  function automatic logic is_wide(input logic [3:0] opc);
    return (opc == OP_ADD32) || (opc == OP_SUB32);
  endfunction

  function automatic logic is_arith(input logic [3:0] opc);
    return (opc == OP_ADD) || (opc == OP_SUB) ||
           (opc == OP_ADD32) || (opc == OP_SUB32);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command/response handshake bundle between a host and alu_op_sequencer.
// master = host side (issues commands), slave = sequencer side.
interface alu_op_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_cout;
  logic        out_zero;
  logic        out_ovf;
  logic        out_illegal;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result,
    input  out_cout, out_zero, out_ovf, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result,
    output out_cout, out_zero, out_ovf, out_illegal
  );
endinterface

// File: rtl/alu_16bit.sv
// Combinational 16-bit ALU: optional A/B inversion, AND/OR/XOR/ADD/LESS.
// Ports: a, b, cin, ainvert, bnegate, less, op in; result, cout out.
module alu_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  input  logic        ainvert,
  input  logic        bnegate,
  input  logic        less,
  input  logic [2:0]  op,
  output logic [15:0] result,
  output logic        cout
);
  logic [15:0] aa;
  logic [15:0] bb;
  logic [16:0] sum;

  assign aa  = ainvert ? ~a : a;
  assign bb  = bnegate ? ~b : b;
  assign sum = {1'b0, aa} + {1'b0, bb} + {16'b0, cin};
  assign cout = sum[16];

  always_comb begin
    result = '0;
    case (op)
      3'b000:  result = aa & bb;
      3'b010:  result = aa | bb;
      3'b011:  result = aa ^ bb;
      3'b100:  result = sum[15:0];
      3'b111:  result = {15'b0, less};
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// Drives alu_16bit one pass per cycle; chains two passes for 32-bit ops.
// Ports: clk, reset, bus (slave handshake), alu_* drive/return lines.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           reset,
  alu_op_sequencer_if.slave bus,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_cin,
  output logic           alu_ainvert,
  output logic           alu_bnegate,
  output logic           alu_less,
  output logic [2:0]     alu_op,
  input  logic [W-1:0]   alu_result,
  input  logic           alu_cout
);

  state_t       state;
  logic [3:0]   op_q;
  logic [W-1:0] a_hi;
  logic [W-1:0] b_hi;
  logic [W-1:0] lo_q;
  alu_ctl_t     ctl;
  logic         b_eff_msb;
  logic         pass_ovf;
  logic         slt_bit;

  assign ctl = decode_op(bus.in_op);
  assign alu_less = 1'b0;

  // Overflow of the pass currently on the ALU, from the operands we drive.
  assign b_eff_msb = alu_b[W-1] ^ alu_bnegate;
  assign pass_ovf  = (alu_a[W-1] ~^ b_eff_msb) &
                     (alu_a[W-1] ^ alu_result[W-1]);
  assign slt_bit   = alu_result[W-1] ^ pass_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      op_q            <= '0;
      a_hi            <= '0;
      b_hi            <= '0;
      lo_q            <= '0;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_cin         <= 1'b0;
      alu_ainvert     <= 1'b0;
      alu_bnegate     <= 1'b0;
      alu_op          <= '0;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.out_result  <= '0;
      bus.out_cout    <= 1'b0;
      bus.out_zero    <= 1'b0;
      bus.out_ovf     <= 1'b0;
      bus.out_illegal <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q         <= bus.in_op;
            a_hi         <= bus.in_a[2*W-1:W];
            b_hi         <= bus.in_b[2*W-1:W];
            bus.in_ready <= 1'b0;
            if (ctl.legal) begin
              alu_a       <= bus.in_a[W-1:0];
              alu_b       <= bus.in_b[W-1:0];
              alu_cin     <= ctl.cin;
              alu_ainvert <= ctl.ainvert;
              alu_bnegate <= ctl.bnegate;
              alu_op      <= ctl.op;
              state       <= S_EXEC_LO;
            end else begin
              bus.out_valid   <= 1'b1;
              bus.out_result  <= '0;
              bus.out_cout    <= 1'b0;
              bus.out_zero    <= 1'b1;
              bus.out_ovf     <= 1'b0;
              bus.out_illegal <= 1'b1;
              state           <= S_DONE;
            end
          end
        end
        S_EXEC_LO: begin
          lo_q <= alu_result;
          if (is_wide(op_q)) begin
            // High pass keeps op/bnegate; carry chains through cin.
            alu_a   <= a_hi;
            alu_b   <= b_hi;
            alu_cin <= alu_cout;
            state   <= S_EXEC_HI;
          end else begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_cin     <= 1'b0;
            alu_ainvert <= 1'b0;
            alu_bnegate <= 1'b0;
            alu_op      <= '0;
            bus.out_valid   <= 1'b1;
            bus.out_illegal <= 1'b0;
            if (op_q == OP_SLT) begin
              bus.out_result <= {{(2*W-1){1'b0}}, slt_bit};
              bus.out_zero   <= ~slt_bit;
              bus.out_cout   <= 1'b0;
              bus.out_ovf    <= 1'b0;
            end else begin
              bus.out_result <= {{W{1'b0}}, alu_result};
              bus.out_zero   <= (alu_result == '0);
              bus.out_cout   <= is_arith(op_q) & alu_cout;
              bus.out_ovf    <= is_arith(op_q) & pass_ovf;
            end
            state <= S_DONE;
          end
        end
        S_EXEC_HI: begin
          alu_a       <= '0;
          alu_b       <= '0;
          alu_cin     <= 1'b0;
          alu_ainvert <= 1'b0;
          alu_bnegate <= 1'b0;
          alu_op      <= '0;
          bus.out_valid   <= 1'b1;
          bus.out_illegal <= 1'b0;
          bus.out_result  <= {alu_result, lo_q};
          bus.out_zero    <= (alu_result == '0) && (lo_q == '0);
          bus.out_cout    <= alu_cout;
          bus.out_ovf     <= pass_ovf;
          state           <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed + random bench for alu_op_sequencer driving alu_16bit.
// Expected values come from a plain-arithmetic reference model.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_op_sequencer_if bus ();

  logic [15:0] alu_a, alu_b, alu_result;
  logic        alu_cin, alu_ainvert, alu_bnegate, alu_less, alu_cout;
  logic [2:0]  alu_op;

  alu_op_sequencer #(.W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_ainvert(alu_ainvert), .alu_bnegate(alu_bnegate),
    .alu_less(alu_less), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  alu_16bit alu (
    .a(alu_a), .b(alu_b), .cin(alu_cin),
    .ainvert(alu_ainvert), .bnegate(alu_bnegate),
    .less(alu_less), .op(alu_op),
    .result(alu_result), .cout(alu_cout)
  );

  typedef struct {
    logic [31:0] result;
    logic        cout;
    logic        zero;
    logic        ovf;
    logic        illegal;
    int          lat;
  } exp_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ovf_range(input longint s, input int bits);
    longint hi, lo;
    hi = (longint'(1) <<< (bits - 1)) - 1;
    lo = -(longint'(1) <<< (bits - 1));
    return (s > hi) || (s < lo);
  endfunction

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    logic [15:0] a16, b16, r16;
    longint ua, ub, sa, sb, u;
    a16 = a[15:0];
    b16 = b[15:0];
    ua = longint'(a16);
    ub = longint'(b16);
    sa = longint'($signed(a16));
    sb = longint'($signed(b16));
    e.result = 32'h0; e.cout = 1'b0; e.ovf = 1'b0;
    e.illegal = 1'b0; e.lat = 2;
    case (op)
      OP_AND: e.result = {16'h0, a16 & b16};
      OP_OR:  e.result = {16'h0, a16 | b16};
      OP_XOR: e.result = {16'h0, a16 ^ b16};
      OP_NOR: e.result = {16'h0, ~(a16 | b16)};
      OP_ADD: begin
        r16 = a16 + b16;
        e.result = {16'h0, r16};
        e.cout = (ua + ub) > 65535;
        e.ovf = ovf_range(sa + sb, 16);
      end
      OP_SUB: begin
        r16 = a16 - b16;
        e.result = {16'h0, r16};
        e.cout = (ua >= ub);
        e.ovf = ovf_range(sa - sb, 16);
      end
      OP_SLT: e.result = (sa < sb) ? 32'd1 : 32'd0;
      OP_ADD32: begin
        u = longint'(a) + longint'(b);
        e.result = a + b;
        e.cout = u > 64'hFFFF_FFFF;
        e.ovf = ovf_range(longint'($signed(a)) + longint'($signed(b)), 32);
        e.lat = 3;
      end
      OP_SUB32: begin
        e.result = a - b;
        e.cout = (a >= b);
        e.ovf = ovf_range(longint'($signed(a)) - longint'($signed(b)), 32);
        e.lat = 3;
      end
      default: begin
        e.illegal = 1'b1;
        e.lat = 1;
      end
    endcase
    e.zero = (e.result == 32'h0);
    return e;
  endfunction

  // Called #1 after a clock edge; returns #1 after the accept edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    check("ready_before_accept", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_a = a;
    bus.in_b = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a = $urandom;
    bus.in_b = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_resp(input string tag, input exp_t e, input int lat);
    check({tag, "_latency"}, 64'(lat), 64'(e.lat));
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_result"}, 64'(bus.out_result), 64'(e.result));
    check({tag, "_flags"},
          64'({bus.out_cout, bus.out_zero, bus.out_ovf, bus.out_illegal}),
          64'({e.cout, e.zero, e.ovf, e.illegal}));
    check({tag, "_alu_idle"},
          64'({alu_a, alu_b, alu_op, alu_cin, alu_bnegate, alu_ainvert}),
          64'd0);
  endtask

  task automatic release_resp();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("released_valid", 64'(bus.out_valid), 64'd0);
    check("released_ready", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run(input string tag, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b);
    int lat;
    exp_t e;
    e = model(op, a, b);
    send(op, a, b);
    wait_valid(lat);
    check_resp(tag, e, lat);
    release_resp();
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_FFFF;
      2: return 32'h0000_8000;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    exp_t e;
    logic [31:0] ra, rb;
    logic [3:0] rop;

    bus.in_valid = 1'b0;
    bus.in_op = '0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(bus.in_ready), 64'd1);
    check("reset_outs",
          64'({bus.out_valid, bus.out_result, bus.out_cout,
               bus.out_zero, bus.out_ovf, bus.out_illegal}), 64'd0);
    check("reset_alu", 64'({alu_a, alu_b, alu_op, alu_cin,
                            alu_bnegate, alu_ainvert, alu_less}), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_ready", 64'(bus.in_ready), 64'd1);

    run("add", OP_ADD, 32'h000F, 32'h000E);
    run("sub", OP_SUB, 32'h000F, 32'h000E);
    run("sub_neg", OP_SUB, 32'd1001, 32'd12341);
    run("slt", OP_SLT, 32'd1001, 32'd12341);
    run("add32", OP_ADD32, 32'h0000_FFFF, 32'h0000_0001);
    run("sub32", OP_SUB32, 32'h0, 32'h1);
    run("illegal", 4'd12, 32'h1234_5678, 32'h9ABC_DEF0);
    run("nor", OP_NOR, 32'h00F0, 32'h0F00);
    run("and_zero", OP_AND, 32'h0001, 32'h0000);
    run("add_ovf", OP_ADD, 32'h7FFF, 32'h0001);
    run("slt_ovf", OP_SLT, 32'h8000, 32'h0001);

    // Back-pressure with a second command waiting.
    e = model(OP_ADD, 32'd5, 32'd6);
    send(OP_ADD, 32'd5, 32'd6);
    wait_valid(lat);
    check_resp("bp_first", e, lat);
    bus.in_valid = 1'b1;
    bus.in_op = OP_XOR;
    bus.in_a = 32'h0000_A5A5;
    bus.in_b = 32'h0000_0FF0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      check("bp_hold_ready", 64'(bus.in_ready), 64'd0);
      check("bp_hold_result", 64'(bus.out_result), 64'(e.result));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp_release_ready", 64'(bus.in_ready), 64'd1);
    check("bp_release_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("bp_second_accept", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    bus.in_a = 32'hFFFF_FFFF;
    e = model(OP_XOR, 32'h0000_A5A5, 32'h0000_0FF0);
    wait_valid(lat);
    check_resp("bp_second", e, lat);
    release_resp();

    // Reset during the high pass of an ADD32.
    send(OP_ADD32, 32'h1234_0001, 32'h0001_0002);
    @(posedge clk);
    #1;
    check("rst_in_exec_hi", 64'(alu_a), 64'h1234);
    reset = 1'b1;
    #1;
    check("rst_async_ready", 64'(bus.in_ready), 64'd1);
    check("rst_async_valid", 64'(bus.out_valid), 64'd0);
    check("rst_async_alu",
          64'({alu_a, alu_b, alu_op, alu_cin, alu_bnegate}), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("rst_no_stale", 64'(bus.out_valid), 64'd0);
    end
    run("after_reset", OP_OR, 32'h0000_1200, 32'h0000_0034);

    // Random commands against the reference model.
    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra = pick_operand();
      rb = pick_operand();
      run("rand", rop, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
